// File: rtl/fifo_pkg.sv
// Pointer helpers shared by both sides of the asynchronous FIFO.
// Functions work on 32-bit values; callers zero-extend and truncate to pointer width.
package fifo_pkg;

   localparam int GW = 32;

   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b[GW-1] = g[GW-1];
      for (int i = GW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry in-order output buffer; push lands at the tail, pop removes the head.
// Zero added latency; head and count change only on push or pop.
module fifo_out_skid #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [1:0]            count,
   output logic [DATA_WIDTH-1:0] head
);

   logic [DATA_WIDTH-1:0] tail;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               // With one entry the incoming word becomes the new head directly.
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller: owns the read pointer, fetches from RAM, presents FWFT stream.
// Sync pointer change to dout_valid is 3 cycles; prefetch holds at most 2 words under backpressure.
module async_fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH          = 3,
   parameter int DATA_WIDTH          = 8,
   parameter int ALMOST_EMPTY_THRESH = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
   output logic [ADDR_WIDTH:0]   rptr_gray,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_level
);

   localparam int PW = ptr_width(ADDR_WIDTH);
   localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_THRESH);

   logic [PW-1:0] rbin;
   logic [PW-1:0] rbin_nxt;
   logic [PW-1:0] rgray_nxt;
   logic [PW-1:0] wbin;
   logic [PW-1:0] level_nxt;
   logic          pend;
   logic [1:0]    out_cnt;
   logic [2:0]    occ;
   logic          pop;

   assign pop        = dout_valid && dout_ready;
   assign dout_valid = (out_cnt != 2'd0);
   assign mem_raddr  = rbin[ADDR_WIDTH-1:0];

   // Occupancy after this cycle counting the word in flight from RAM.
   assign occ     = {1'b0, out_cnt} + {2'b00, pend} - {2'b00, pop};
   assign mem_ren = !empty && (occ < 3'd2);

   assign rbin_nxt  = rbin + {{(PW-1){1'b0}}, mem_ren};
   assign rgray_nxt = PW'(bin2gray(GW'(rbin_nxt)));
   assign wbin      = PW'(gray2bin(GW'(wptr_gray_sync)));
   assign level_nxt = wbin - rbin_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rbin         <= '0;
         rptr_gray    <= '0;
         pend         <= 1'b0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_level     <= '0;
      end else begin
         rbin         <= rbin_nxt;
         rptr_gray    <= rgray_nxt;
         pend         <= mem_ren;
         empty        <= (rgray_nxt == wptr_gray_sync);
         almost_empty <= (level_nxt <= AE_TH);
         rd_level     <= level_nxt;
      end
   end

   fifo_out_skid #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (pend),
      .push_data (mem_rdata),
      .pop       (pop),
      .count     (out_cnt),
      .head      (dout)
   );

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl with a behavioural RAM and write-side pointer.
module tb_async_fifo_rd_ctrl;

   localparam int AW = 3;
   localparam int DW = 8;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] wptr_gray_sync;
   logic [PW-1:0] rptr_gray;
   logic          mem_ren;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          empty;
   logic          almost_empty;
   logic [PW-1:0] rd_level;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [DW-1:0] ram [0:7];
   logic [PW-1:0] wbin;

   logic [DW-1:0] got [$];
   logic [AW-1:0] addrs [$];
   int            fetch_cyc [$];
   int            pop_cyc [$];
   int            gray_err = 0;
   int            ren_in_reset = 0;
   logic [PW-1:0] prev_rptr = '0;

   async_fifo_rd_ctrl #(
      .ADDR_WIDTH          (AW),
      .DATA_WIDTH          (DW),
      .ALMOST_EMPTY_THRESH (1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .wptr_gray_sync (wptr_gray_sync),
      .rptr_gray      (rptr_gray),
      .mem_ren        (mem_ren),
      .mem_raddr      (mem_raddr),
      .mem_rdata      (mem_rdata),
      .dout           (dout),
      .dout_valid     (dout_valid),
      .dout_ready     (dout_ready),
      .empty          (empty),
      .almost_empty   (almost_empty),
      .rd_level       (rd_level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (mem_ren) mem_rdata <= ram[mem_raddr];
   end

   always @(negedge clk) begin
      if (reset && mem_ren) ren_in_reset++;
      if (mem_ren) begin
         addrs.push_back(mem_raddr);
         fetch_cyc.push_back(cyc);
      end
      if (dout_valid && dout_ready) begin
         got.push_back(dout);
         pop_cyc.push_back(cyc);
      end
      if (!reset && rptr_gray != prev_rptr && $countones(rptr_gray ^ prev_rptr) != 1) gray_err++;
      prev_rptr = rptr_gray;
   end

   function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      got.delete();
      addrs.delete();
      fetch_cyc.delete();
      pop_cyc.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wbin = '0;
      wptr_gray_sync = '0;
      step();
      step();
      reset = 1'b0;
      step();
      clear_mon();
   endtask

   initial begin
      reset = 1'b1;
      wbin = '0;
      wptr_gray_sync = '0;
      dout_ready = 1'b0;
      for (int i = 0; i < 8; i++) ram[i] = '0;
      #1;
      chk("rst_empty_async", 32'(empty), 1);
      chk("rst_valid_async", 32'(dout_valid), 0);
      repeat (3) step();
      reset = 1'b0;
      repeat (10) step();
      chk("idle_rptr", 32'(rptr_gray), 0);
      chk("idle_valid", 32'(dout_valid), 0);
      chk("idle_dout", 32'(dout), 0);
      chk("idle_empty", 32'(empty), 1);
      chk("idle_aempty", 32'(almost_empty), 1);
      chk("idle_level", 32'(rd_level), 0);
      chk("idle_no_fetch", 32'(addrs.size()), 0);

      // single word
      dout_ready = 1'b1;
      ram[0] = 8'h11;
      wbin = 4'd1;
      wptr_gray_sync = gray(wbin);
      chk("one_k_ren", 32'(mem_ren), 0);
      step();
      chk("one_k1_ren", 32'(mem_ren), 1);
      chk("one_k1_raddr", 32'(mem_raddr), 0);
      chk("one_k1_empty", 32'(empty), 0);
      chk("one_k1_level", 32'(rd_level), 1);
      step();
      chk("one_k2_ren", 32'(mem_ren), 0);
      chk("one_k2_valid", 32'(dout_valid), 0);
      step();
      chk("one_k3_valid", 32'(dout_valid), 1);
      chk("one_k3_dout", 32'(dout), 32'h11);
      step();
      chk("one_after_valid", 32'(dout_valid), 0);
      chk("one_after_rptr", 32'(rptr_gray), 32'h1);
      chk("one_after_empty", 32'(empty), 1);

      // eight words streamed
      do_reset();
      dout_ready = 1'b1;
      for (int i = 0; i < 8; i++) ram[i] = 8'(8'h20 + i);
      wbin = 4'd8;
      wptr_gray_sync = gray(wbin);
      repeat (14) step();
      chk("eight_nfetch", 32'(addrs.size()), 8);
      chk("eight_npop", 32'(got.size()), 8);
      for (int i = 0; i < 8; i++) begin
         chk("eight_raddr", 32'(addrs[i]), 32'(i));
         chk("eight_data", 32'(got[i]), 32'(8'h20 + i));
      end
      chk("eight_fetch_span", 32'(fetch_cyc[7] - fetch_cyc[0]), 7);
      chk("eight_pop_span", 32'(pop_cyc[7] - pop_cyc[0]), 7);
      chk("eight_rptr", 32'(rptr_gray), 32'hC);
      chk("eight_empty", 32'(empty), 1);

      // backpressure
      do_reset();
      dout_ready = 1'b0;
      for (int i = 0; i < 5; i++) ram[i] = 8'(8'h30 + i);
      wbin = 4'd5;
      wptr_gray_sync = gray(wbin);
      repeat (8) step();
      chk("bp_nfetch", 32'(addrs.size()), 2);
      chk("bp_level", 32'(rd_level), 3);
      chk("bp_aempty", 32'(almost_empty), 0);
      chk("bp_empty", 32'(empty), 0);
      chk("bp_ren", 32'(mem_ren), 0);
      chk("bp_valid", 32'(dout_valid), 1);
      chk("bp_dout", 32'(dout), 32'h30);
      dout_ready = 1'b1;
      repeat (10) step();
      chk("bp_npop", 32'(got.size()), 5);
      chk("bp_nfetch_all", 32'(addrs.size()), 5);
      for (int i = 0; i < 5; i++) chk("bp_data", 32'(got[i]), 32'(8'h30 + i));
      chk("bp_level_end", 32'(rd_level), 0);
      chk("bp_aempty_end", 32'(almost_empty), 1);

      // twenty words across two wraps
      do_reset();
      dout_ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
         ram[wbin[2:0]] = 8'(8'h40 + n);
         wbin = wbin + 4'd1;
         wptr_gray_sync = gray(wbin);
         step();
      end
      repeat (12) step();
      chk("wrap_npop", 32'(got.size()), 20);
      chk("wrap_nfetch", 32'(addrs.size()), 20);
      for (int i = 0; i < 20; i++) begin
         chk("wrap_data", 32'(got[i]), 32'(8'h40 + i));
         chk("wrap_raddr", 32'(addrs[i]), 32'(i % 8));
      end
      chk("wrap_rptr", 32'(rptr_gray), 32'h6);
      chk("wrap_gray_steps", 32'(gray_err), 0);

      // reset mid-operation with a word buffered and one in flight
      do_reset();
      dout_ready = 1'b0;
      for (int i = 0; i < 5; i++) ram[i] = 8'(8'h50 + i);
      wbin = 4'd5;
      wptr_gray_sync = gray(wbin);
      repeat (3) step();
      chk("mid_pre_valid", 32'(dout_valid), 1);
      chk("mid_pre_dout", 32'(dout), 32'h50);
      reset = 1'b1;
      #1;
      chk("mid_valid", 32'(dout_valid), 0);
      chk("mid_dout", 32'(dout), 0);
      chk("mid_empty", 32'(empty), 1);
      chk("mid_aempty", 32'(almost_empty), 1);
      chk("mid_level", 32'(rd_level), 0);
      chk("mid_rptr", 32'(rptr_gray), 0);
      chk("mid_ren", 32'(mem_ren), 0);
      wbin = '0;
      wptr_gray_sync = '0;
      step();
      step();
      reset = 1'b0;
      clear_mon();
      repeat (4) step();
      chk("mid_idle_fetch", 32'(addrs.size()), 0);
      chk("mid_ren_in_reset", 32'(ren_in_reset), 0);
      ram[0] = 8'h5A;
      wbin = 4'd1;
      wptr_gray_sync = gray(wbin);
      dout_ready = 1'b1;
      repeat (5) step();
      chk("restart_nfetch", 32'(addrs.size()), 1);
      chk("restart_raddr", 32'(addrs[0]), 0);
      chk("restart_npop", 32'(got.size()), 1);
      chk("restart_data", 32'(got[0]), 32'h5A);
      chk("restart_rptr", 32'(rptr_gray), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
